// File: rtl/arbitro_pkg.sv
// ----------------------------------------------------------------------------
// arbitro_pkg
// Shared definitions for the tri-state bus arbiter:
//   NREQ            number of requesters sharing the bus
//   ANCHO_SEL       width of the 3-to-8 decoder select
//   estado_t        arbiter state: LIBRE (idle), ASIGNADO (granted),
//                   GIRO (turnaround, no driver on the bus)
//   indice_a_codigo maps a requester index to the decoder select (~i)
// ----------------------------------------------------------------------------
package arbitro_pkg;

    localparam int NREQ      = 8;
    localparam int ANCHO_SEL = 3;

    typedef enum logic [1:0] {
        LIBRE,
        ASIGNADO,
        GIRO
    } estado_t;

    // The board decoder is wired inverted: index 0 drives select 3'b111.
    // The mapping is its own inverse, so it also recovers the index from
    // the select.
    function automatic logic [ANCHO_SEL-1:0] indice_a_codigo(
        input logic [ANCHO_SEL-1:0] indice
    );
        return ~indice;
    endfunction

endpackage

// File: rtl/selector_rr.sv
// ----------------------------------------------------------------------------
// selector_rr
// Combinational round-robin picker. The search starts one position after
// the last winner and wraps around.
// Ports:
//   solicitud [NREQ-1:0]      in   request vector
//   puntero   [ANCHO_SEL-1:0] in   index of the last winner
//   valido                    out  at least one request is pending
//   indice    [ANCHO_SEL-1:0] out  chosen requester (meaningful when valido)
// ----------------------------------------------------------------------------
module selector_rr
    import arbitro_pkg::*;
(
    input  logic [NREQ-1:0]      solicitud,
    input  logic [ANCHO_SEL-1:0] puntero,
    output logic                 valido,
    output logic [ANCHO_SEL-1:0] indice
);

    logic [NREQ-1:0]      rotada;
    logic [ANCHO_SEL-1:0] desplaz;

    // Rotate so that bit 0 is the requester right after puntero, find the
    // lowest set bit, then undo the rotation by adding the offset back.
    // NOTE: every variable gets a default at the top of always_comb, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rotada  = '0;
        desplaz = '0;
        for (int k = 0; k < NREQ; k++) begin
            rotada[k] = solicitud[puntero + ANCHO_SEL'(k + 1)];
        end
        // Scanning downwards lets the lowest set bit win.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotada[k]) begin
                desplaz = ANCHO_SEL'(k);
            end
        end
    end

    assign valido = |solicitud;
    // Three-bit arithmetic wraps modulo NREQ on its own.
    assign indice = puntero + desplaz + ANCHO_SEL'(1);

endmodule

// File: rtl/arbitro_bus_tristate.sv
// ----------------------------------------------------------------------------
// arbitro_bus_tristate
// Round-robin arbiter sharing one tri-state bus among 8 requesters. It
// drives the select of a 3-to-8 decoder plus a drive-enable gating the
// decoder outputs. A turnaround gap with no driver separates grants.
//
// Parameters:
//   TGIRO  turnaround cycles with no driver between grants (>=1)
//   NMAX   max grant length in cycles, used only with ARB_TIMEOUT_EN (>=2)
// Configuration macro:
//   ARB_TIMEOUT_EN  when defined, a grant is forcibly released after NMAX
//                   cycles; otherwise it lasts until the request drops.
// Ports:
//   Reloj       in   clock, rising edge
//   Reset       in   synchronous reset, active-high
//   Solicitud   in   [7:0] level requests, held until served
//   Concesion   out  [7:0] one-hot grant, registered
//   Codigo      out  [2:0] decoder select, index i -> ~i
//   Habilitado  out  bus drive enable, high only while a grant is active
//   Ocupado     out  high whenever the arbiter is not idle
// ----------------------------------------------------------------------------
module arbitro_bus_tristate
    import arbitro_pkg::*;
#(
    parameter int TGIRO = 1,
    parameter int NMAX  = 16
) (
    input  logic                 Reloj,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      Solicitud,
    output logic [NREQ-1:0]      Concesion,
    output logic [ANCHO_SEL-1:0] Codigo,
    output logic                 Habilitado,
    output logic                 Ocupado
);

    if (TGIRO < 1 || NMAX < 2) begin : g_parametros_invalidos
        $error("arbitro_bus_tristate: TGIRO must be >= 1 and NMAX >= 2");
    end

    localparam int ANCHO_GIRO = (TGIRO > 1) ? $clog2(TGIRO) : 1;
    localparam logic [ANCHO_GIRO-1:0] GIRO_ULTIMO = ANCHO_GIRO'(TGIRO - 1);

    estado_t               estado, estado_sig;
    logic [ANCHO_SEL-1:0]  puntero, puntero_sig;
    logic [ANCHO_GIRO-1:0] giro_cnt, giro_sig;
    logic [NREQ-1:0]       conc_sig;
    logic [ANCHO_SEL-1:0]  codigo_sig;
    logic                  hab_sig;
    logic                  liberar;
    logic                  valido;
    logic [ANCHO_SEL-1:0]  indice;
    logic [ANCHO_SEL-1:0]  g;

`ifdef ARB_TIMEOUT_EN
    localparam int ANCHO_CNT = $clog2(NMAX);
    localparam logic [ANCHO_CNT-1:0] CNT_ULTIMO = ANCHO_CNT'(NMAX - 1);
    logic [ANCHO_CNT-1:0] contador, contador_sig;
`endif

    selector_rr u_selector (
        .solicitud (Solicitud),
        .puntero   (puntero),
        .valido    (valido),
        .indice    (indice)
    );

    // Codigo holds ~g for the whole grant, so the owner is recovered from
    // it instead of keeping a second copy of the index.
    assign g = indice_a_codigo(Codigo);

    always_comb begin
        estado_sig = estado;
        puntero_sig = puntero;
        giro_sig = giro_cnt;
        conc_sig = Concesion;
        codigo_sig = Codigo;
        hab_sig = Habilitado;
        liberar = 1'b0;
`ifdef ARB_TIMEOUT_EN
        contador_sig = contador;
`endif
        case (estado)
            LIBRE: begin
                if (valido) begin
                    estado_sig = ASIGNADO;
                    conc_sig   = NREQ'(1) << indice;
                    codigo_sig = indice_a_codigo(indice);
                    hab_sig    = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    contador_sig = '0;
`endif
                end
            end
            ASIGNADO: begin
`ifdef ARB_TIMEOUT_EN
                liberar = !Solicitud[g] || (contador == CNT_ULTIMO);
                contador_sig = contador + 1'b1;
`else
                liberar = !Solicitud[g];
`endif
                // Codigo keeps its last value so the decoder select never
                // glitches while the bus is undriven.
                if (liberar) begin
                    estado_sig  = GIRO;
                    conc_sig    = '0;
                    hab_sig     = 1'b0;
                    puntero_sig = g;
                    giro_sig    = '0;
                end
            end
            GIRO: begin
                if (giro_cnt == GIRO_ULTIMO) begin
                    estado_sig = LIBRE;
                end else begin
                    giro_sig = giro_cnt + 1'b1;
                end
            end
            default: estado_sig = LIBRE;
        endcase
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block
    // and every register, outputs included, takes its reset value on the
    // same edge regardless of state.
    always_ff @(posedge Reloj) begin
        if (Reset) begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples the pre-edge values computed in always_comb.
            estado     <= LIBRE;
            puntero    <= '1;
            giro_cnt   <= '0;
            Concesion  <= '0;
            Codigo     <= '1;
            Habilitado <= 1'b0;
            Ocupado    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            contador   <= '0;
`endif
        end else begin
            estado     <= estado_sig;
            puntero    <= puntero_sig;
            giro_cnt   <= giro_sig;
            Concesion  <= conc_sig;
            Codigo     <= codigo_sig;
            Habilitado <= hab_sig;
            Ocupado    <= (estado_sig != LIBRE);
`ifdef ARB_TIMEOUT_EN
            contador   <= contador_sig;
`endif
        end
    end

endmodule

// File: tb/tb_arbitro_bus_tristate.sv
// ----------------------------------------------------------------------------
// tb_arbitro_bus_tristate
// Self-checking bench for arbitro_bus_tristate. A grant-level reference
// model (owner, last winner, remaining gap, grant age) predicts every
// output after every clock edge; directed sequences check ordering, gap
// lengths, reset behaviour and, depending on ARB_TIMEOUT_EN, the timeout.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_arbitro_bus_tristate;

    localparam int TGIRO = 1;
    localparam int NMAX  = 16;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       Reloj;
    logic       Reset;
    logic [7:0] Solicitud;
    logic [7:0] Concesion;
    logic [2:0] Codigo;
    logic       Habilitado;
    logic       Ocupado;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, who won last, cycles of turnaround
    // still to run, how many cycles the current grant has been visible.
    int         m_owner;
    int         m_last;
    int         m_gap;
    int         m_held;
    logic [2:0] m_code;

    arbitro_bus_tristate #(.TGIRO(TGIRO), .NMAX(NMAX)) dut (
        .Reloj      (Reloj),
        .Reset      (Reset),
        .Solicitud  (Solicitud),
        .Concesion  (Concesion),
        .Codigo     (Codigo),
        .Habilitado (Habilitado),
        .Ocupado    (Ocupado)
    );

    initial begin
        Reloj = 1'b0;
        forever #5 Reloj = ~Reloj;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (Reset) begin
            m_owner = -1;
            m_last  = 7;
            m_gap   = 0;
            m_held  = 0;
            m_code  = 3'd7;
        end else if (m_owner >= 0) begin
            if (!Solicitud[m_owner] || (TIMEOUT && m_held == NMAX)) begin
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = TGIRO;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (Solicitud != 8'd0) begin
            for (int d = 1; d <= 8; d++) begin
                int i;
                i = (m_last + d) % 8;
                if (Solicitud[i]) begin
                    m_owner = i;
                    m_held  = 1;
                    m_code  = 3'(7 - i);
                    break;
                end
            end
        end
    endtask

    // One clock: advance the model with the values the DUT samples, then
    // compare all outputs 1 ns after the edge.
    task automatic tick();
        logic [7:0] e_conc;
        @(posedge Reloj);
        model_step();
        #1;
        e_conc = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        check("concesion", Concesion, e_conc);
        check("codigo", {5'd0, Codigo}, {5'd0, m_code});
        check("habilitado", {7'd0, Habilitado}, {7'd0, (m_owner >= 0)});
        check("ocupado", {7'd0, Ocupado}, {7'd0, (m_owner >= 0 || m_gap > 0)});
        check("onehot0", {7'd0, $onehot0(Concesion)}, 8'd1);
    endtask

    // Ticks until a grant shows up; gap counts the grant-less cycles seen.
    task automatic wait_grant(output int gap);
        gap = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (Habilitado === 1'b1) return;
            gap++;
        end
        check("grant_wait_budget", {7'd0, Habilitado}, 8'd1);
    endtask

    // Called right after a grant appears; returns its length in cycles.
    task automatic measure_hold(output int len);
        len = 1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (Habilitado !== 1'b1) return;
            len++;
        end
    endtask

    initial begin
        int         gap;
        int         len;
        int         n;
        logic [7:0] one;

        // 1. Reset held with every request raised.
        Reset = 1'b1;
        Solicitud = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("rst_conc", Concesion, 8'h00);
            check("rst_cod", {5'd0, Codigo}, 8'h07);
            check("rst_hab", {7'd0, Habilitado}, 8'h00);
            check("rst_ocup", {7'd0, Ocupado}, 8'h00);
        end

        // 2. Single request from idle, then drop together with a new request.
        Reset = 1'b0;
        Solicitud = 8'h00;
        repeat (2) tick();
        Solicitud = 8'h04;
        tick();
        check("t2_conc", Concesion, 8'h04);
        check("t2_cod", {5'd0, Codigo}, 8'h05);
        check("t2_hab", {7'd0, Habilitado}, 8'h01);
        repeat (2) tick();
        Solicitud = 8'h08;
        wait_grant(gap);
        check("t2_gap", 8'(gap), 8'(TGIRO + 1));
        check("t2_next", Concesion, 8'h08);
        Solicitud = 8'h00;
        repeat (4) tick();

        // 3. Everyone requests; each winner keeps the bus for 3 cycles.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Solicitud = 8'hFF;
        wait_grant(gap);
        for (int k = 0; k < 8; k++) begin
            one = 8'd1 << k;
            check("t3_order", Concesion, one);
            if (k > 0) check("t3_gap", 8'(gap), 8'(TGIRO + 1));
            repeat (2) tick();
            Solicitud[k] = 1'b0;
            if (k < 7) wait_grant(gap);
        end
        repeat (4) tick();

        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Solicitud = 8'h81;
`ifdef ARB_TIMEOUT_EN
        // 4. Two held requests alternate, each cut at NMAX cycles.
        wait_grant(gap);
        check("t4_first", Concesion, 8'h01);
        measure_hold(len);
        check("t4_len0", 8'(len), 8'(NMAX));
        wait_grant(gap);
        check("t4_gap0", 8'(gap + 1), 8'(TGIRO + 1));
        check("t4_second", Concesion, 8'h80);
        measure_hold(len);
        check("t4_len7", 8'(len), 8'(NMAX));
        wait_grant(gap);
        check("t4_gap7", 8'(gap + 1), 8'(TGIRO + 1));
        check("t4_third", Concesion, 8'h01);
`else
        // 5. Without timeout the first winner keeps the bus indefinitely.
        wait_grant(gap);
        check("t5_first", Concesion, 8'h01);
        n = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (Concesion === 8'h01) n++;
        end
        check("t5_held", 8'(n), 8'd100);
`endif

        // 6. Reset during a grant to index 5, then a fresh search from 0.
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Solicitud = 8'h20;
        wait_grant(gap);
        check("t6_conc", Concesion, 8'h20);
        check("t6_cod", {5'd0, Codigo}, 8'h02);
        repeat (2) tick();
        Reset = 1'b1;
        tick();
        check("t6_rst_conc", Concesion, 8'h00);
        check("t6_rst_cod", {5'd0, Codigo}, 8'h07);
        check("t6_rst_hab", {7'd0, Habilitado}, 8'h00);
        check("t6_rst_ocup", {7'd0, Ocupado}, 8'h00);
        Reset = 1'b0;
        Solicitud = 8'h21;
        tick();
        check("t6_win0", Concesion, 8'h01);

        // Random traffic: requests accumulate, owners release at random,
        // with an occasional reset.
        Reset = 1'b1;
        Solicitud = 8'h00;
        tick();
        Reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) Solicitud = Solicitud | 8'($urandom_range(0, 255));
            if (m_owner >= 0 && $urandom_range(0, 2) == 0) Solicitud[m_owner] = 1'b0;
            Reset = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
